// File: rtl/spi_reg_bank.sv
// SPI mode-0 target register bank. Pad inputs are synchronised into clk; frames are
// {rw, addr, data} MSB first and writes commit only when exactly TOTAL bits were clocked.
module spi_reg_bank #(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       err_pulse
);
  localparam int HDR_LEN = 1 + ADDR_W;
  localparam int TOTAL   = HDR_LEN + DATA_W;
  localparam int CNT_W   = $clog2(TOTAL + 2);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(HDR_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(TOTAL + 1);
  localparam logic [ADDR_W:0]  NREGS    = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, HDR, DATA, COMMIT} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, copi_sync_q;
  logic                   sclk_dly_q, ncs_dly_q;
  logic                   sclk_s, ncs_s, copi_s;
  logic                   sclk_rise_s, sclk_fall_s, ncs_rise_s, ncs_fall_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TOTAL-1:0]       in_sh_q, in_sh_d;
  logic                   rw_q, rw_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      out_sh_q, out_sh_d;
  logic                   cipo_oe_q, cipo_oe_d;
  logic                   wr_pulse_q, wr_pulse_d;
  logic                   err_pulse_q, err_pulse_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

  logic [TOTAL-1:0]       hdr_word_s;
  logic [ADDR_W-1:0]      hdr_addr_s;
  logic                   hdr_rw_s;
  logic [DATA_W-1:0]      rd_val_s;
  logic                   addr_ok_s;

  // Pad synchronisers plus one delayed copy of the last stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      ncs_sync_q  <= {SYNC_STAGES{1'b1}};
      copi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      ncs_dly_q   <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
  assign copi_s      = copi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_dly_q;
  assign sclk_fall_s = ~sclk_s & sclk_dly_q;
  assign ncs_rise_s  = ncs_s & ~ncs_dly_q;
  assign ncs_fall_s  = ~ncs_s & ncs_dly_q;

  // The in-shifter as it will look after the current rising edge; header fields come from it.
  assign hdr_word_s = {in_sh_q[TOTAL-2:0], copi_s};
  assign hdr_addr_s = hdr_word_s[ADDR_W-1:0];
  assign hdr_rw_s   = hdr_word_s[ADDR_W];
  assign addr_ok_s  = ({1'b0, addr_q} < NREGS);

  // Read-back mux; an out-of-range address matches no register and yields zero.
  always_comb begin
    rd_val_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      rd_val_s = rd_val_s | ((hdr_addr_s == ADDR_W'(k)) ? regs_q[k] : {DATA_W{1'b0}});
    end
  end

  // Frame FSM and datapath next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_sh_d     = in_sh_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    out_sh_d    = out_sh_q;
    cipo_oe_d   = cipo_oe_q;
    wr_pulse_d  = 1'b0;
    err_pulse_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    regs_d      = regs_q;
    case (state_q)
      IDLE: begin
        if (ncs_fall_s) begin
          state_d  = HDR;
          cnt_d    = {CNT_W{1'b0}};
          in_sh_d  = {TOTAL{1'b0}};
          out_sh_d = {DATA_W{1'b0}};
          rw_d     = 1'b0;
          addr_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (ncs_rise_s) begin
          state_d = COMMIT;
        end else if (sclk_rise_s) begin
          cnt_d   = cnt_q + CNT_W'(1);
          in_sh_d = hdr_word_s;
          if (cnt_q == CNT_HDR - CNT_W'(1)) begin
            state_d = DATA;
            rw_d    = hdr_rw_s;
            addr_d  = hdr_addr_s;
            if (!hdr_rw_s) begin
              out_sh_d  = rd_val_s;
              cipo_oe_d = 1'b1;
            end else begin
              out_sh_d = {DATA_W{1'b0}};
            end
          end else begin
            state_d = HDR;
          end
        end else begin
          state_d = HDR;
        end
      end
      DATA: begin
        if (ncs_rise_s) begin
          state_d = COMMIT;
        end else if (sclk_rise_s) begin
          if (cnt_q < CNT_FULL) begin
            in_sh_d = hdr_word_s;
          end else begin
            in_sh_d = in_sh_q;
          end
          if (cnt_q != CNT_OVR) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else if (sclk_fall_s && !rw_q && (cnt_q > CNT_HDR)) begin
          // The first falling edge after the header keeps the MSB on the line.
          out_sh_d = {out_sh_q[DATA_W-2:0], 1'b0};
        end else begin
          state_d = DATA;
        end
      end
      COMMIT: begin
        state_d   = IDLE;
        cipo_oe_d = 1'b0;
        out_sh_d  = {DATA_W{1'b0}};
        if ((cnt_q == CNT_FULL) && addr_ok_s) begin
          if (rw_q) begin
            wr_pulse_d = 1'b1;
            wr_addr_d  = addr_q;
            for (int k = 0; k < NUM_REGS; k++) begin
              regs_d[k] = (addr_q == ADDR_W'(k)) ? in_sh_q[DATA_W-1:0] : regs_q[k];
            end
          end else begin
            wr_pulse_d = 1'b0;
          end
        end else begin
          err_pulse_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      in_sh_q     <= {TOTAL{1'b0}};
      rw_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      out_sh_q    <= {DATA_W{1'b0}};
      cipo_oe_q   <= 1'b0;
      wr_pulse_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      wr_addr_q   <= {ADDR_W{1'b0}};
      regs_q      <= {(NUM_REGS*DATA_W){1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_sh_q     <= in_sh_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      out_sh_q    <= out_sh_d;
      cipo_oe_q   <= cipo_oe_d;
      wr_pulse_q  <= wr_pulse_d;
      err_pulse_q <= err_pulse_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  assign cipo      = out_sh_q[DATA_W-1];
  assign cipo_oe   = cipo_oe_q;
  assign regs_flat = regs_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign err_pulse = err_pulse_q;

endmodule
